// File: rtl/load_store_unit.sv
// load_store_unit
//
// Purpose:
//   Turns an RV32I load/store request from the core into one word-aligned
//   memory bus transaction. It produces byte strobes and lane-replicated
//   write data for stores, and extracts and sign/zero extends the addressed
//   lanes for loads. The core is stalled until the access finishes.
//   Misaligned accesses, unsupported funct3 values and bus timeouts are
//   reported in the done cycle.
//
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   req_valid        memory op present; held stable until done
//   is_load/is_store op kind (is_load wins if both are set)
//   funct3           RV32I size/sign field
//   addr             effective address from the ALU
//   store_data       rs2 value
//   stall            combinational stall back to the core
//   done             one-cycle completion pulse (state DONE)
//   load_data        extended load result, valid while done
//   misaligned       alignment fault, valid while done
//   bus_error        unsupported funct3 or timeout, valid while done
//   mem_req/mem_we   registered bus request and write enable
//   mem_addr         word-aligned bus address
//   mem_wstrb        byte enables (0 for loads)
//   mem_wdata        lane-replicated store data
//   mem_gnt          bus accepted the request
//   mem_rvalid       read data valid
//   mem_rdata        read data
//
// Handshake: mem_req stays high until mem_gnt is sampled high on a rising
// edge; the request is then dropped. For loads, mem_rvalid is honoured only
// in the cycles after the grant edge (state WAIT).

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic             op_load;
  logic [2:0]       op_f3;
  logic [1:0]       op_lo;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             req_unsup;
  logic             req_misal;
  logic             timed_out;
  logic [3:0]       strb_c;
  logic [31:0]      wdata_c;

  assign accept    = (state == S_IDLE) && req_valid && (is_load || is_store);
  assign timed_out = (cnt == TO_LAST);
  assign stall     = req_valid && (is_load || is_store) && (state != S_DONE);
  assign done      = (state == S_DONE);

  // Request decode on the live inputs; only used in the accept cycle.
  always_comb begin
    req_unsup = 1'b0;
    req_misal = 1'b0;
    strb_c    = 4'b0000;
    wdata_c   = store_data;
    if (is_load)
      req_unsup = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                    funct3 == 3'b100 || funct3 == 3'b101);
    else
      req_unsup = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
    case (funct3[1:0])
      2'b01: req_misal = addr[0];
      2'b10: req_misal = (addr[1:0] != 2'b00);
      default: req_misal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb_c  = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      2'b10: strb_c = 4'b1111;
      default: strb_c = 4'b0000;
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [2:0] f3,
                                           input logic [1:0] lo,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = rd[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h000000, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0000, h};
      default: return rd;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (req_unsup || req_misal) ? S_DONE : S_REQ;
      S_REQ: begin
        // A grant in the last allowed cycle still completes the access.
        if (mem_gnt)        state_next = op_load ? S_WAIT : S_DONE;
        else if (timed_out) state_next = S_DONE;
      end
      S_WAIT: if (mem_rvalid || timed_out) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_load    <= 1'b0;
      op_f3      <= 3'b000;
      op_lo      <= 2'b00;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'h0;
      load_data  <= 32'h0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_load   <= is_load;
            op_f3     <= funct3;
            op_lo     <= addr[1:0];
            cnt       <= '0;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_we    <= !is_load;
            mem_wstrb <= is_load ? 4'b0000 : strb_c;
            mem_wdata <= wdata_c;
            if (req_unsup)      bus_error  <= 1'b1;
            else if (req_misal) misaligned <= 1'b1;
            else                mem_req    <= 1'b1;
          end
        end
        S_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_gnt) mem_req <= 1'b0;
          else if (timed_out) begin
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_rvalid)     load_data <= fmt_load(op_f3, op_lo, mem_rdata);
          else if (timed_out) bus_error <= 1'b1;
        end
        S_DONE: begin
          misaligned <= 1'b0;
          bus_error  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
